// File: rtl/rf_sb.sv
// rtl/rf_sb.sv - register file with per-register busy scoreboard and sequential bulk clear
//
// Purpose: NREGS x DATA_W register file with two combinational read ports, one
// synchronous write port, a busy bit per register (set by issue, cleared by
// write), and a clear engine that zeroes one register per cycle.
//
// Optional feature macro: RF_SB_BYPASS_EN (write-to-read forwarding on the
// read ports in the same cycle as write_en).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   read1_reg/read2_reg      read indices
//   read1_data/read2_data    combinational read data
//   read1_busy/read2_busy    scoreboard bit for the read indices
//   write_en/reg/data        writeback strobe, index, data
//   issue_en/issue_reg       mark a register as having an outstanding producer
//   clear_req                single-cycle bulk-clear request
//   clr_busy                 high while the clear engine runs

module rf_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read1_reg,
  input  logic [ADDR_W-1:0] read2_reg,
  output logic [DATA_W-1:0] read1_data,
  output logic [DATA_W-1:0] read2_data,
  output logic              read1_busy,
  output logic              read2_busy,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_reg,
  input  logic              clear_req,
  output logic              clr_busy
);

  localparam int NREGS = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_idx;

  // Accesses aimed at a hard-wired zero register are dropped entirely.
  logic wr_ok;
  logic iss_ok;
  logic z1;
  logic z2;

  assign wr_ok  = write_en && !(ZR && (write_reg == '0));
  assign iss_ok = issue_en && !(ZR && (issue_reg == '0));
  assign z1     = ZR && (read1_reg == '0);
  assign z2     = ZR && (read2_reg == '0);

  assign clr_busy = (state == ST_CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      busy    <= '0;
      state   <= ST_IDLE;
      clr_idx <= '0;
    end else if (state == ST_CLEAR) begin
      // Upstream is stalled on clr_busy, so write/issue/clear_req are ignored here.
      regs[clr_idx] <= '0;
      busy[clr_idx] <= 1'b0;
      clr_idx       <= clr_idx + 1'b1;
      if (clr_idx == ADDR_W'(NREGS - 1)) begin
        state <= ST_IDLE;
      end
    end else begin
      if (clear_req) begin
        state   <= ST_CLEAR;
        clr_idx <= '0;
      end
      if (wr_ok) begin
        regs[write_reg] <= write_data;
        busy[write_reg] <= 1'b0;
      end
      // Issue after write so a same-index issue leaves the bit set.
      if (iss_ok) begin
        busy[issue_reg] <= 1'b1;
      end
    end
  end

`ifdef RF_SB_BYPASS_EN
  logic byp1;
  logic byp2;

  assign byp1 = wr_ok && (state == ST_IDLE) && (write_reg == read1_reg);
  assign byp2 = wr_ok && (state == ST_IDLE) && (write_reg == read2_reg);

  always_comb begin
    read1_data = regs[read1_reg];
    read1_busy = busy[read1_reg];
    if (byp1) begin
      read1_data = write_data;
      // A same-cycle issue to this index keeps the stored busy view.
      if (!(issue_en && (issue_reg == read1_reg))) begin
        read1_busy = 1'b0;
      end
    end
    if (z1) begin
      read1_data = '0;
      read1_busy = 1'b0;
    end
  end

  always_comb begin
    read2_data = regs[read2_reg];
    read2_busy = busy[read2_reg];
    if (byp2) begin
      read2_data = write_data;
      if (!(issue_en && (issue_reg == read2_reg))) begin
        read2_busy = 1'b0;
      end
    end
    if (z2) begin
      read2_data = '0;
      read2_busy = 1'b0;
    end
  end
`else
  assign read1_data = z1 ? '0 : regs[read1_reg];
  assign read2_data = z2 ? '0 : regs[read2_reg];
  assign read1_busy = z1 ? 1'b0 : busy[read1_reg];
  assign read2_busy = z2 ? 1'b0 : busy[read2_reg];
`endif

endmodule

// File: tb/tb_rf_sb.sv
// tb/tb_rf_sb.sv - self-checking bench for rf_sb (ZERO_REG=0 and ZERO_REG=1 instances)

module tb_rf_sb;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] read1_reg, read2_reg, write_reg, issue_reg;
  logic          write_en, issue_en, clear_req;
  logic [DW-1:0] write_data;

  logic [1:0][DW-1:0] r1d, r2d;
  logic [1:0]         r1b, r2b, cb;

  int checks = 0;
  int errors = 0;

  // Reference model: index 0 = plain file, index 1 = zero-register file.
  logic [DW-1:0] m_mem  [2][N];
  bit            m_busy [2][N];
  bit            m_clr;
  int            m_pos;

  always #5 clk = ~clk;

  rf_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut (
    .clk(clk), .rst(rst),
    .read1_reg(read1_reg), .read2_reg(read2_reg),
    .read1_data(r1d[0]), .read2_data(r2d[0]),
    .read1_busy(r1b[0]), .read2_busy(r2b[0]),
    .write_en(write_en), .write_reg(write_reg), .write_data(write_data),
    .issue_en(issue_en), .issue_reg(issue_reg),
    .clear_req(clear_req), .clr_busy(cb[0])
  );

  rf_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst),
    .read1_reg(read1_reg), .read2_reg(read2_reg),
    .read1_data(r1d[1]), .read2_data(r2d[1]),
    .read1_busy(r1b[1]), .read2_busy(r2b[1]),
    .write_en(write_en), .write_reg(write_reg), .write_data(write_data),
    .issue_en(issue_en), .issue_reg(issue_reg),
    .clear_req(clear_req), .clr_busy(cb[1])
  );

  function automatic logic [DW-1:0] exp_data(int d, logic [AW-1:0] idx);
    if (d == 1 && idx == 0) return '0;
`ifdef RF_SB_BYPASS_EN
    if (write_en && !m_clr && write_reg == idx) return write_data;
`endif
    return m_mem[d][idx];
  endfunction

  function automatic logic exp_busy(int d, logic [AW-1:0] idx);
    if (d == 1 && idx == 0) return 1'b0;
`ifdef RF_SB_BYPASS_EN
    if (write_en && !m_clr && write_reg == idx && !(issue_en && issue_reg == idx)) return 1'b0;
`endif
    return m_busy[d][idx];
  endfunction

  task automatic model_edge();
    if (rst) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < N; i++) begin
          m_mem[d][i]  = '0;
          m_busy[d][i] = 1'b0;
        end
      m_clr = 1'b0;
      m_pos = 0;
    end else if (m_clr) begin
      for (int d = 0; d < 2; d++) begin
        m_mem[d][m_pos]  = '0;
        m_busy[d][m_pos] = 1'b0;
      end
      m_pos++;
      if (m_pos == N) begin
        m_clr = 1'b0;
        m_pos = 0;
      end
    end else begin
      if (clear_req) begin
        m_clr = 1'b1;
        m_pos = 0;
      end
      for (int d = 0; d < 2; d++) begin
        if (write_en && !(d == 1 && write_reg == 0)) begin
          m_mem[d][write_reg]  = write_data;
          m_busy[d][write_reg] = 1'b0;
        end
        if (issue_en && !(d == 1 && issue_reg == 0)) m_busy[d][issue_reg] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    rst = 1'b0; write_en = 1'b0; issue_en = 1'b0; clear_req = 1'b0;
  endtask

  task automatic do_write(logic [AW-1:0] r, logic [DW-1:0] v);
    set_idle();
    write_en = 1'b1; write_reg = r; write_data = v;
    tick();
    set_idle();
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1; read1_reg = '0; read2_reg = '0; write_reg = '0; issue_reg = '0; write_data = '0;
    tick(); tick();
    set_idle();
    for (int i = 0; i < N; i++) begin
      read1_reg = AW'(i); read2_reg = AW'(N - 1 - i);
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (r1d[d] !== '0 || r2d[d] !== '0 || r1b[d] !== 1'b0 || r2b[d] !== 1'b0 || cb[d] !== 1'b0) begin
          errors++;
          $display("FAIL reset dut%0d idx %0d: d1=%h d2=%h b1=%b b2=%b clr=%b, required all 0", d, i, r1d[d], r2d[d], r1b[d], r2b[d], cb[d]);
        end
      end
    end
  endtask

  task automatic test_write_read();
    do_write(3'd5, 32'hDEADBEEF);
    read1_reg = 3'd5; read2_reg = 3'd5;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (r1d[d] !== 32'hDEADBEEF || r2d[d] !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL write_read dut%0d: d1=%h d2=%h, required deadbeef", d, r1d[d], r2d[d]);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (i == 5) continue;
      read1_reg = AW'(i); read2_reg = AW'(i);
      #1;
      checks++;
      if (r1d[0] !== '0 || r2d[0] !== '0) begin
        errors++;
        $display("FAIL other_regs idx %0d: d1=%h d2=%h, required 0", i, r1d[0], r2d[0]);
      end
    end
  endtask

  task automatic test_zero_reg();
    do_write(3'd0, 32'h12345678);
    read1_reg = 3'd0;
    #1;
    checks++;
    if (r1d[1] !== '0) begin
      errors++;
      $display("FAIL zero_reg_data: got %h, required 0", r1d[1]);
    end
    checks++;
    if (r1d[0] !== 32'h12345678) begin
      errors++;
      $display("FAIL plain_reg0_data: got %h, required 12345678", r1d[0]);
    end
    issue_en = 1'b1; issue_reg = 3'd0;
    tick();
    set_idle();
    checks++;
    if (r1b[1] !== 1'b0 || r1b[0] !== 1'b1) begin
      errors++;
      $display("FAIL zero_reg_busy: zero=%b plain=%b, required 0 and 1", r1b[1], r1b[0]);
    end
    do_write(3'd0, 32'h0);
  endtask

  task automatic test_scoreboard();
    read1_reg = 3'd3;
    issue_en = 1'b1; issue_reg = 3'd3;
    tick();
    set_idle();
    checks++;
    if (r1b !== 2'b11) begin
      errors++;
      $display("FAIL sb_issue: busy=%b, required 11", r1b);
    end
    do_write(3'd3, 32'h33);
    checks++;
    if (r1b !== 2'b00 || r1d[0] !== 32'h33) begin
      errors++;
      $display("FAIL sb_write: busy=%b data=%h, required 00 and 33", r1b, r1d[0]);
    end
    write_en = 1'b1; write_reg = 3'd3; write_data = 32'h77;
    issue_en = 1'b1; issue_reg = 3'd3;
    tick();
    set_idle();
    checks++;
    if (r1b !== 2'b11 || r1d[0] !== 32'h77 || r1d[1] !== 32'h77) begin
      errors++;
      $display("FAIL sb_set_wins: busy=%b data=%h/%h, required 11 and 77", r1b, r1d[0], r1d[1]);
    end
    do_write(3'd3, 32'h0);
  endtask

  task automatic test_bypass();
    logic [DW-1:0] want_d;
    logic          want_b;
    do_write(3'd2, 32'h22);
    issue_en = 1'b1; issue_reg = 3'd2;
    tick();
    set_idle();
    read2_reg = 3'd2; read1_reg = 3'd6;
    write_en = 1'b1; write_reg = 3'd2; write_data = 32'hA5A5A5A5;
    #1;
`ifdef RF_SB_BYPASS_EN
    want_d = 32'hA5A5A5A5; want_b = 1'b0;
`else
    want_d = 32'h22; want_b = 1'b1;
`endif
    checks++;
    if (r2d[0] !== want_d || r2b[0] !== want_b) begin
      errors++;
      $display("FAIL bypass_same_cycle: data=%h busy=%b, required %h %b", r2d[0], r2b[0], want_d, want_b);
    end
    tick();
    set_idle();
    checks++;
    if (r2d[0] !== 32'hA5A5A5A5 || r2b[0] !== 1'b0) begin
      errors++;
      $display("FAIL bypass_next_cycle: data=%h busy=%b, required a5a5a5a5 0", r2d[0], r2b[0]);
    end
  endtask

  task automatic test_bulk_clear();
    int high_cycles;
    high_cycles = 0;
    for (int k = 0; k < N; k++) do_write(AW'(k), 32'h11111111 * (k + 1));
    clear_req = 1'b1;
    tick();
    set_idle();
    for (int c = 1; c <= 9; c++) begin
      set_idle();
      if (c <= 8) begin
        write_en = 1'b1; write_reg = 3'd7; write_data = 32'hFFFFFFFF;
        issue_en = 1'b1; issue_reg = 3'd6;
        read2_reg = AW'(c - 1);
      end else begin
        write_en = 1'b1; write_reg = 3'd4; write_data = 32'h44;
      end
      read1_reg = (c >= 2) ? AW'(c - 2) : 3'd0;
      #1;
      if (cb[0] === 1'b1) high_cycles++;
      checks++;
      if (cb[0] !== (c <= 8) || cb[1] !== (c <= 8)) begin
        errors++;
        $display("FAIL clr_busy cycle %0d: got %b, required %b", c, cb, (c <= 8) ? 2'b11 : 2'b00);
      end
      if (c >= 2) begin
        checks++;
        if (r1d !== '0) begin
          errors++;
          $display("FAIL cleared reg %0d cycle %0d: got %h/%h, required 0", c - 2, c, r1d[0], r1d[1]);
        end
      end
      if (c <= 8) begin
        checks++;
        if (r2d[0] !== 32'h11111111 * c) begin
          errors++;
          $display("FAIL pending reg %0d cycle %0d: got %h, required %h", c - 1, c, r2d[0], 32'h11111111 * c);
        end
      end
      tick();
    end
    set_idle();
    checks++;
    if (high_cycles != 8) begin
      errors++;
      $display("FAIL clr_busy_len: got %0d cycles, required 8", high_cycles);
    end
    read1_reg = 3'd7; read2_reg = 3'd4;
    #1;
    checks++;
    if (r1d[0] !== '0 || r2d[0] !== 32'h44) begin
      errors++;
      $display("FAIL post_clear: reg7=%h reg4=%h, required 0 and 44", r1d[0], r2d[0]);
    end
    read1_reg = 3'd6;
    #1;
    checks++;
    if (r1b[0] !== 1'b0) begin
      errors++;
      $display("FAIL clear_issue_dropped: busy6=%b, required 0", r1b[0]);
    end
  endtask

  task automatic test_reset_mid_clear();
    int guard;
    do_write(3'd0, 32'hAA); do_write(3'd1, 32'hBB); do_write(3'd5, 32'hCC);
    clear_req = 1'b1;
    tick();
    set_idle();
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    set_idle();
    checks++;
    if (cb !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_clr_busy: got %b, required 00", cb);
    end
    for (int i = 0; i < N; i++) begin
      read1_reg = AW'(i);
      #1;
      checks++;
      if (r1d[0] !== '0 || r1b[0] !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset reg %0d: data=%h busy=%b, required 0 0", i, r1d[0], r1b[0]);
      end
    end
    do_write(3'd0, 32'hAA); do_write(3'd1, 32'hBB);
    clear_req = 1'b1;
    tick();
    set_idle();
    tick();
    read1_reg = 3'd0; read2_reg = 3'd1;
    #1;
    checks++;
    if (r1d[0] !== '0 || r2d[0] !== 32'hBB) begin
      errors++;
      $display("FAIL restart_index: reg0=%h reg1=%h, required 0 and bb", r1d[0], r2d[0]);
    end
    guard = 0;
    while (cb[0] === 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    checks++;
    if (cb[0] !== 1'b0) begin
      errors++;
      $display("FAIL restart_timeout: clr_busy still %b, required 0", cb[0]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 49) == 0);
      clear_req  = ($urandom_range(0, 19) == 0);
      write_en   = $urandom_range(0, 1);
      issue_en   = ($urandom_range(0, 2) == 0);
      write_reg  = AW'($urandom_range(0, N - 1));
      issue_reg  = AW'($urandom_range(0, N - 1));
      read1_reg  = AW'($urandom_range(0, N - 1));
      read2_reg  = ($urandom_range(0, 3) == 0) ? write_reg : AW'($urandom_range(0, N - 1));
      write_data = $urandom;
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (r1d[d] !== exp_data(d, read1_reg) || r2d[d] !== exp_data(d, read2_reg) ||
            r1b[d] !== exp_busy(d, read1_reg) || r2b[d] !== exp_busy(d, read2_reg) || cb[d] !== m_clr) begin
          errors++;
          $display("FAIL random n=%0d dut%0d: d1=%h d2=%h b1=%b b2=%b clr=%b, required %h %h %b %b %b",
                   n, d, r1d[d], r2d[d], r1b[d], r2b[d], cb[d],
                   exp_data(d, read1_reg), exp_data(d, read2_reg), exp_busy(d, read1_reg), exp_busy(d, read2_reg), m_clr);
        end
      end
      tick();
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_scoreboard();
    test_bypass();
    test_bulk_clear();
    test_reset_mid_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_sb.md
# rf_sb

Parametrised general-purpose register file with a per-register busy scoreboard and a sequential bulk-clear engine. It sits between decode and writeback in the core datapath and provides two combinational read ports and one synchronous write port. It also tracks which registers have an outstanding producer, so hazard logic can stall on `readN_busy`. It generalises the fixed 8x32 register file to arbitrary width and depth, with an optional hard-wired zero register and optional write-to-read bypass.

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 3, register index width; `NREGS = 2**ADDR_W`
- `ZERO_REG`, 0, if 1 then register 0 always reads 0, writes to it are discarded, and it is never busy

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `read1_reg`  in  ADDR_W  read port 1 index
- `read2_reg`  in  ADDR_W  read port 2 index
- `read1_data`  out  DATA_W  combinational read data, port 1
- `read2_data`  out  DATA_W  combinational read data, port 2
- `read1_busy`  out  1  scoreboard bit for `read1_reg`
- `read2_busy`  out  1  scoreboard bit for `read2_reg`
- `write_en`  in  1  writeback strobe
- `write_reg`  in  ADDR_W  writeback index
- `write_data`  in  DATA_W  writeback data
- `issue_en`  in  1  marks `issue_reg` as having an outstanding producer
- `issue_reg`  in  ADDR_W  destination index of the issuing instruction
- `clear_req`  in  1  single-cycle request to start the bulk clear
- `clr_busy`  out  1  high while the clear engine runs

## Operation
- Storage: `NREGS` x `DATA_W` flops, plus `NREGS` busy bits.
- Read: `readN_data = reg[readN_reg]`; with `ZERO_REG=1` and index 0, the output is 0.
- Write: on the clock edge, if `write_en` is high, `reg[write_reg] <= write_data` and `busy[write_reg] <= 0`. Writes to reg 0 are dropped when `ZERO_REG=1`.
- Issue: on the clock edge, if `issue_en` is high, `busy[issue_reg] <= 1`.
- If `issue_en` and `write_en` target the same index in the same cycle, set wins: the busy bit ends at 1 and the data is still written.
- `readN_busy = busy[readN_reg]`, subject to the bypass rule below.
- Clear FSM has two states, IDLE and CLEAR, with counter `clr_idx` (ADDR_W bits).
  - IDLE: `clear_req` moves to CLEAR and sets `clr_idx <= 0`.
  - CLEAR: each cycle, `reg[clr_idx] <= 0` and `busy[clr_idx] <= 0`, then `clr_idx` increments.
  - When `clr_idx == NREGS-1`, the FSM returns to IDLE on that edge.
  - The clear takes exactly `NREGS` cycles.
- Rules while in CLEAR:
  - `write_en`, `issue_en` and further `clear_req` are ignored. Upstream must stall on `clr_busy`.
  - Reads continue and return current contents: 0 for already-cleared indices, old values otherwise.
- Reset (`rst` high at an edge), including mid-clear:
  - all registers become 0, all busy bits become 0, FSM goes to IDLE, `clr_idx` becomes 0.
  - `rst` has priority over every other input.

## Timing
- Read latency is 0 (combinational).
- A write is visible on the read ports in the cycle after `write_en`. Same-cycle visibility exists only with bypass.
- A busy bit set by issue is visible the cycle after `issue_en`.
- `clr_busy` rises the cycle after `clear_req` and stays high for `NREGS` cycles.
- After reset: `read1_data = read2_data = 0`, `read1_busy = read2_busy = 0`, `clr_busy = 0`.
- Writes are accepted again on the first cycle `clr_busy` is low.

## Configuration
- Macro `RF_SB_BYPASS_EN`.
- Defined, when `write_en` is high, outside CLEAR, and `write_reg == readN_reg` (and that index is not reg 0 with `ZERO_REG=1`):
  - `readN_data = write_data` in the same cycle.
  - `readN_busy = 0` in the same cycle, unless `issue_en` targets the same index that cycle.
- Undefined: no forwarding. Reads and busy bits reflect state as of the last edge only.

## Test plan
- **Reset and basic write/read:** with `ZERO_REG=0`, reset, write 0xDEADBEEF to reg 5, read on both ports next cycle -> 0xDEADBEEF; all other indices read 0.
- **Zero register:** with `ZERO_REG=1`, write 0x12345678 to reg 0 -> reg 0 reads 0; `issue_en` on reg 0 -> `read1_busy` stays 0.
- **Scoreboard:**
  - issue reg 3 -> `read1_busy` = 1 next cycle.
  - write reg 3 -> busy = 0 next cycle.
  - issue and write reg 3 in the same cycle -> busy = 1, data updated.
- **Bulk clear:** fill all 8 registers with non-zero values, pulse `clear_req` -> `clr_busy` high for exactly 8 cycles. Reg k reads 0 from cycle k+2 after the request. A `write_en` during the clear is dropped.
- **Reset mid-clear:** assert `rst` on the 4th CLEAR cycle -> all registers 0, `clr_busy` = 0 next cycle, a new `clear_req` restarts at index 0.
- **Bypass:** with `RF_SB_BYPASS_EN`, write 0xA5A5A5A5 to reg 2 while `read2_reg`=2 -> `read2_data` = 0xA5A5A5A5 and `read2_busy` = 0 in the same cycle. Without the macro -> old value in the same cycle, new value next cycle.
